// File: rtl/dma_mem_responder.sv
// dma_mem_responder
//   Memory-side target for the DMA controller's system-bus transfers. The
//   16-bit address is rebuilt from the upper byte strobed on DBIn (ADSTB) and
//   the lower byte on ALo. MEMR_N/MEMW_N strobes that hit the address window
//   are served from an internal byte array. Wait states are inserted by
//   pulling READY low.
//
// Parameters
//   MEM_AW      byte-address width of the internal array (2**MEM_AW bytes)
//   BASE_ADDR   window base; only bits [15:MEM_AW] take part in the compare
//   WAIT_STATES READY-low cycles per access (0..15)
//
// Ports
//   Clock, Reset       rising-edge clock, asynchronous active-high reset
//   AEN                DMA owns the bus; qualifies ADSTB and both strobes
//   ADSTB              upper-address strobe; DBIn carries A[15:8] while high
//   ALo                lower address A[7:0]
//   DBIn               system data bus as seen by the responder
//   DBOut, DBOutEn     read data and its tristate enable
//   MEMR_N, MEMW_N     active-low memory read / write strobes
//   READY              low while wait states are being inserted
//   ProtocolErr        sticky flag: both strobes seen low together in IDLE
//   BdWe, BdAddr,
//   BdWData, BdRData   backdoor port for preload and readback of the array

module dma_mem_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              AEN,
  input  logic              ADSTB,
  input  logic [7:0]        ALo,
  input  logic [7:0]        DBIn,
  output logic [7:0]        DBOut,
  output logic              DBOutEn,
  input  logic              MEMR_N,
  input  logic              MEMW_N,
  output logic              READY,
  output logic              ProtocolErr,
  input  logic              BdWe,
  input  logic [MEM_AW-1:0] BdAddr,
  input  logic [7:0]        BdWData,
  output logic [7:0]        BdRData
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RWAIT  = 3'd1,
    ST_RDRIVE = 3'd2,
    ST_WWAIT  = 3'd3,
    ST_WDONE  = 3'd4
  } state_t;

  logic [7:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              dbout_en_q, dbout_en_d;
  logic [7:0]        dbout_q, dbout_d;
  logic              perr_q, perr_d;

  logic [15:0]       addr;
  logic [MEM_AW-1:0] addr_idx;
  logic              hit;
  logic              rd_req;
  logic              wr_req;
  logic              both_req;
  logic              strobe_held;
  logic [7:0]        mem_at_idx;
  logic [7:0]        mem_at_addr;
  logic              bus_we;
  logic [MEM_AW-1:0] bus_widx;

  assign addr     = {addr_hi_q, ALo};
  assign addr_idx = addr[MEM_AW-1:0];
  assign hit      = AEN && (addr[15:MEM_AW] == BASE_ADDR[15:MEM_AW]);

  assign rd_req   = AEN && !MEMR_N &&  MEMW_N;
  assign wr_req   = AEN &&  MEMR_N && !MEMW_N;
  assign both_req = AEN && !MEMR_N && !MEMW_N;

  // During a wait phase only the strobe that started the access matters;
  // losing it or losing AEN aborts the access.
  assign strobe_held = AEN && ((state_q == ST_RWAIT) ? !MEMR_N : !MEMW_N);

  assign mem_at_idx  = mem[idx_q];
  assign mem_at_addr = mem[addr_idx];
  assign BdRData     = mem[BdAddr];

  assign DBOut       = dbout_q;
  assign DBOutEn     = dbout_en_q;
  assign READY       = ready_q;
  assign ProtocolErr = perr_q;

  always_comb begin
    state_d    = state_q;
    addr_hi_d  = (AEN && ADSTB) ? DBIn : addr_hi_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    dbout_en_d = dbout_en_q;
    dbout_d    = dbout_q;
    perr_d     = perr_q;
    bus_we     = 1'b0;
    bus_widx   = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d    = 1'b1;
        dbout_en_d = 1'b0;
        cnt_d      = '0;
        if (both_req) begin
          perr_d = 1'b1;
        end else if (rd_req && hit) begin
          idx_d = addr_idx;
          if (WS == 4'd0) begin
            state_d    = ST_RDRIVE;
            dbout_en_d = 1'b1;
            dbout_d    = mem_at_addr;
          end else begin
            state_d = ST_RWAIT;
            ready_d = 1'b0;
            cnt_d   = 4'd1;
          end
        end else if (wr_req && hit) begin
          idx_d = addr_idx;
          if (WS == 4'd0) begin
            state_d  = ST_WDONE;
            bus_we   = 1'b1;
            bus_widx = addr_idx;
          end else begin
            state_d = ST_WWAIT;
            ready_d = 1'b0;
            cnt_d   = 4'd1;
          end
        end
      end

      ST_RWAIT, ST_WWAIT: begin
        if (!strobe_held) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == WS) begin
          // Last wait cycle: release READY on this edge and complete.
          ready_d = 1'b1;
          cnt_d   = '0;
          if (state_q == ST_RWAIT) begin
            state_d    = ST_RDRIVE;
            dbout_en_d = 1'b1;
            dbout_d    = mem_at_idx;
          end else begin
            state_d = ST_WDONE;
            bus_we  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_RDRIVE: begin
        ready_d    = 1'b1;
        dbout_en_d = 1'b1;
        dbout_d    = mem_at_idx;
        if (MEMR_N) begin
          state_d    = ST_IDLE;
          dbout_en_d = 1'b0;
        end
      end

      ST_WDONE: begin
        ready_d = 1'b1;
        if (MEMW_N) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
        dbout_en_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      addr_hi_q  <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      dbout_en_q <= 1'b0;
      dbout_q    <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_hi_q  <= addr_hi_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      dbout_en_q <= dbout_en_d;
      dbout_q    <= dbout_d;
      perr_q     <= perr_d;
    end
  end

  // Array is not reset. The backdoor write is issued last so it wins over a
  // bus write to the same index on the same edge.
  always_ff @(posedge Clock) begin
    if (bus_we) begin
      mem[bus_widx] <= DBIn;
    end
    if (BdWe) begin
      mem[BdAddr] <= BdWData;
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;

  localparam int WS1 = 1;
  localparam int WS3 = 3;

  logic       clk;
  logic       rst;
  logic       aen;
  logic       adstb;
  logic [7:0] alo;
  logic [7:0] dbin;
  logic       memr_n;
  logic       memw_n;
  logic       bd_we;
  logic [9:0] bd_addr;
  logic [7:0] bd_wdata;

  logic [7:0] dbout1, dbout3;
  logic       en1, en3;
  logic       ready1, ready3;
  logic       perr1, perr3;
  logic [7:0] bdr1, bdr3;

  // Reference contents of each instance's array.
  logic [7:0] mem1 [1024];
  logic [7:0] mem3 [1024];

  int checks = 0;
  int errors = 0;

  dma_mem_responder #(.MEM_AW(10), .BASE_ADDR(16'h0000), .WAIT_STATES(WS1)) dut1 (
    .Clock(clk), .Reset(rst), .AEN(aen), .ADSTB(adstb), .ALo(alo), .DBIn(dbin),
    .DBOut(dbout1), .DBOutEn(en1), .MEMR_N(memr_n), .MEMW_N(memw_n),
    .READY(ready1), .ProtocolErr(perr1), .BdWe(bd_we), .BdAddr(bd_addr),
    .BdWData(bd_wdata), .BdRData(bdr1)
  );

  dma_mem_responder #(.MEM_AW(10), .BASE_ADDR(16'h0000), .WAIT_STATES(WS3)) dut3 (
    .Clock(clk), .Reset(rst), .AEN(aen), .ADSTB(adstb), .ALo(alo), .DBIn(dbin),
    .DBOut(dbout3), .DBOutEn(en3), .MEMR_N(memr_n), .MEMW_N(memw_n),
    .READY(ready3), .ProtocolErr(perr3), .BdWe(bd_we), .BdAddr(bd_addr),
    .BdWData(bd_wdata), .BdRData(bdr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lows(input bit hit, input int ws, input int hold);
    if (!hit) return 0;
    return (hold < ws) ? hold : ws;
  endfunction

  task automatic check_backdoor(input logic [9:0] idx);
    bd_addr = idx;
    #1;
    check_eq("bd1", bdr1, mem1[idx]);
    check_eq("bd3", bdr3, mem3[idx]);
  endtask

  // One bus access: address phase, strobe held for 'hold' cycles, release.
  task automatic bus_access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                            input int hold);
    int lo1, lo3;
    bit hit;
    bit done1, done3;
    logic [9:0] idx;
    hit   = (a[15:10] == 6'd0);
    idx   = a[9:0];
    done1 = hit && (hold >= WS1 + 1);
    done3 = hit && (hold >= WS3 + 1);

    aen = 1'b1; adstb = 1'b1; dbin = a[15:8]; alo = a[7:0];
    @(negedge clk);
    adstb = 1'b0;
    dbin  = is_wr ? d : 8'($urandom);
    if (is_wr) memw_n = 1'b0; else memr_n = 1'b0;
    lo1 = 0; lo3 = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!ready1) lo1++;
      if (!ready3) lo3++;
      alo = 8'($urandom);  // must not disturb the captured index
    end
    check_eq("ready_lo1", lo1, exp_lows(hit, WS1, hold));
    check_eq("ready_lo3", lo3, exp_lows(hit, WS3, hold));
    if (is_wr) begin
      check_eq("wr_en1", en1, 1'b0);
      check_eq("wr_en3", en3, 1'b0);
    end else begin
      check_eq("rd_en1", en1, done1);
      check_eq("rd_en3", en3, done3);
      if (done1) check_eq("rd_data1", dbout1, mem1[idx]);
      if (done3) check_eq("rd_data3", dbout3, mem3[idx]);
    end
    memr_n = 1'b1; memw_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready1", ready1, 1'b1);
    check_eq("rel_ready3", ready3, 1'b1);
    check_eq("rel_en1", en1, 1'b0);
    check_eq("rel_en3", en3, 1'b0);
    if (is_wr && done1) mem1[idx] = d;
    if (is_wr && done3) mem3[idx] = d;
    check_backdoor(idx);
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] a;
    logic [7:0]  hi;

    rst = 1'b1; aen = 1'b0; adstb = 1'b0; alo = '0; dbin = '0;
    memr_n = 1'b1; memw_n = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready1", ready1, 1'b1);
    check_eq("rst_ready3", ready3, 1'b1);
    check_eq("rst_en1", en1, 1'b0);
    check_eq("rst_dbout1", dbout1, 8'h00);
    check_eq("rst_perr1", perr1, 1'b0);
    check_eq("rst_perr3", perr3, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Preload both arrays through the backdoor.
    for (int i = 0; i < 1024; i++) begin
      v = (i == 'h034) ? 8'hA5 : 8'($urandom);
      bd_we = 1'b1; bd_addr = 10'(i); bd_wdata = v;
      mem1[i] = v; mem3[i] = v;
      @(negedge clk);
    end
    bd_we = 1'b0;

    // Directed accesses.
    bus_access(1'b0, 16'h0034, 8'h00, 6);
    check_eq("dir_a5", mem1[10'h034], 8'hA5);
    bus_access(1'b1, 16'h01FF, 8'h5C, 3);
    check_eq("dir_5c", bdr1, 8'h5C);
    bus_access(1'b0, 16'h8034, 8'h00, 6);
    v = mem3[10'h100];
    bus_access(1'b1, 16'h0100, 8'h3C ^ v, 2);
    check_eq("abort_keep3", bdr3, v);

    // Randomised accesses, mostly hits with occasional misses and aborts.
    for (int n = 0; n < 150; n++) begin
      hi = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      a  = {hi, 8'($urandom)};
      bus_access(1'($urandom_range(0, 1)), a, 8'($urandom), int'($urandom_range(1, 7)));
    end

    // Both strobes low in IDLE.
    check_eq("perr_pre1", perr1, 1'b0);
    aen = 1'b1; memr_n = 1'b0; memw_n = 1'b0;
    @(negedge clk);
    memr_n = 1'b1; memw_n = 1'b1;
    @(negedge clk);
    check_eq("perr1", perr1, 1'b1);
    check_eq("perr3", perr3, 1'b1);
    check_eq("perr_en1", en1, 1'b0);
    check_eq("perr_en3", en3, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("perr_sticky1", perr1, 1'b1);
    check_eq("perr_sticky3", perr3, 1'b1);

    // Reset while both instances drive read data.
    aen = 1'b1; adstb = 1'b1; dbin = 8'h00; alo = 8'h34;
    @(negedge clk);
    adstb = 1'b0; memr_n = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_en1", en1, 1'b1);
    check_eq("pre_rst_en3", en3, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_en1", en1, 1'b0);
    check_eq("arst_en3", en3, 1'b0);
    check_eq("arst_ready1", ready1, 1'b1);
    check_eq("arst_ready3", ready3, 1'b1);
    check_eq("arst_perr1", perr1, 1'b0);
    memr_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_backdoor(10'($urandom));
    end
    check_backdoor(10'h034);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
